// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Issues one calculator command at a time into the decoder/ALU/mux datapath.
// After a fixed settle time it captures the selected result and error flags,
// and checks that the decoder's one-hot select matches the issued opcode.
// It then returns one response per command.
module calc_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [3:0]       opCode,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [15:0]      hotselect,
  input  logic [WIDTH-1:0] muxout,
  input  logic [1:0]       errorCode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [1:0]       rsp_error,
  output logic             rsp_sel_err,
  output logic [7:0]       err_count,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // NO-OP is what the datapath sees whenever no command is in flight
  localparam logic [3:0] OpNoop  = 4'hE;
  localparam logic [3:0] LatLoad = 4'(LAT);

  state_t           stateQ, stateD;
  logic [3:0]       cntQ, cntD;
  logic [3:0]       opCodeQ, opCodeD;
  logic [WIDTH-1:0] opAQ, opAD;
  logic [WIDTH-1:0] opBQ, opBD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic [1:0]       rspErrQ, rspErrD;
  logic             selErrQ, selErrD;
  logic [7:0]       errCountQ, errCountD;

  logic [4:0]       hotOnes;
  logic [3:0]       hotIndex;
  logic             selErrNow;

  // Encode the returned one-hot select: count the set bits and remember the highest index,
  // then flag anything that is not exactly one bit at the issued opcode position
  always_comb begin
    hotOnes  = 5'd0;
    hotIndex = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (hotselect[i]) begin
        hotOnes  = hotOnes + 5'd1;
        hotIndex = 4'(i);
      end
    end
    selErrNow = (hotOnes != 5'd1) || (hotIndex != opCodeQ);
  end

  // Next-state and datapath register updates for the IDLE -> WAIT -> RESP handshake sequence
  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    opCodeD   = opCodeQ;
    opAD      = opAQ;
    opBD      = opBQ;
    resultD   = resultQ;
    rspErrD   = rspErrQ;
    selErrD   = selErrQ;
    errCountD = errCountQ;
    case (stateQ)
      IDLE: begin
        if (cmd_valid) begin
          opCodeD = cmd_op;
          opAD    = cmd_a;
          opBD    = cmd_b;
          cntD    = LatLoad;
          stateD  = WAIT;
        end
      end
      WAIT: begin
        if (cntQ <= 4'd1) begin
          resultD = muxout;
          rspErrD = errorCode;
          selErrD = selErrNow;
          if (((errorCode != 2'b00) || selErrNow) && (errCountQ != 8'hFF)) begin
            errCountD = errCountQ + 8'd1;
          end
          cntD   = 4'd0;
          stateD = RESP;
        end else begin
          cntD = cntQ - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          opCodeD = OpNoop;
          opAD    = '0;
          opBD    = '0;
          stateD  = IDLE;
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight command
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ    <= IDLE;
      cntQ      <= 4'd0;
      opCodeQ   <= OpNoop;
      opAQ      <= '0;
      opBQ      <= '0;
      resultQ   <= '0;
      rspErrQ   <= 2'b00;
      selErrQ   <= 1'b0;
      errCountQ <= 8'd0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      opCodeQ   <= opCodeD;
      opAQ      <= opAD;
      opBQ      <= opBD;
      resultQ   <= resultD;
      rspErrQ   <= rspErrD;
      selErrQ   <= selErrD;
      errCountQ <= errCountD;
    end
  end

  assign cmd_ready   = (stateQ == IDLE);
  assign busy        = (stateQ != IDLE);
  assign rsp_valid   = (stateQ == RESP);
  assign opCode      = opCodeQ;
  assign op_a        = opAQ;
  assign op_b        = opBQ;
  assign rsp_result  = resultQ;
  assign rsp_error   = rspErrQ;
  assign rsp_sel_err = selErrQ;
  assign err_count   = errCountQ;

endmodule
